stopwatch_core: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 52 +++++
 rtl/stopwatch_core_seven_seg_dec.sv | 15 +
 rtl/stopwatch_core.sv | 106 ++++++++++
 tb/tb_stopwatch_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, state encoding and digit helpers
// for the HH:MM:SS stopwatch.
package stopwatch_pkg;

  localparam int DIG_W = 4;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Active-low patterns, index 15 down to 0; 10..15 blank
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Split 0..63 into {tens, ones} with a constant compare chain
  function automatic logic [2*DIG_W-1:0] bcd2(
    input logic [5:0] v
  );
    logic [DIG_W-1:0] t;
    logic [5:0]       r;
    t = '0;
    r = v;
    if (v >= 6'd60) begin
      t = 4'd6;
      r = v - 6'd60;
    end else if (v >= 6'd50) begin
      t = 4'd5;
      r = v - 6'd50;
    end else if (v >= 6'd40) begin
      t = 4'd4;
      r = v - 6'd40;
    end else if (v >= 6'd30) begin
      t = 4'd3;
      r = v - 6'd30;
    end else if (v >= 6'd20) begin
      t = 4'd2;
      r = v - 6'd20;
    end else if (v >= 6'd10) begin
      t = 4'd1;
      r = v - 6'd10;
    end
    return {t, r[DIG_W-1:0]};
  endfunction

endpackage

// File: rtl/stopwatch_core_seven_seg_dec.sv
// One BCD digit to seven-segment pattern,
// bit0 = a .. bit6 = g.
module seven_seg_dec
  import stopwatch_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [DIG_W-1:0] dig_i,
  output logic [6:0]       seg_o
);

  assign seg_o = SEG_ACTIVE_LOW ? SEG_LUT[dig_i]
                                : ~SEG_LUT[dig_i];

endmodule

// File: rtl/stopwatch_core.sv
// Run/pause FSM, HH:MM:SS counters, BCD split
// and six seven-segment displays.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int HR_WRAP        = 24,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  output logic       run,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5
);

  localparam logic [4:0] HR_LAST = 5'(HR_WRAP - 1);

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
    end
  end

  // Pause has priority over start
  always_comb begin
    state_d = state_q;
    if (pause) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
    end
  end

  assign run = (state_q == ST_RUN);

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick && run) begin
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d = '0;
          hr_d  = (hr_q == HR_LAST) ? 5'd0
                                    : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  assign sec = sec_q;
  assign min = min_q;
  assign hr  = hr_q;

  logic [5:0][DIG_W-1:0] dig;
  logic [5:0][6:0]       seg_w;

  assign {dig[1], dig[0]} = bcd2(sec_q);
  assign {dig[3], dig[2]} = bcd2(min_q);
  assign {dig[5], dig[4]} = bcd2({1'b0, hr_q});

  for (genvar g = 0; g < 6; g++) begin : g_seg
    seven_seg_dec #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .dig_i(dig[g]),
      .seg_o(seg_w[g])
    );
  end

  assign seg0 = seg_w[0];
  assign seg1 = seg_w[1];
  assign seg2 = seg_w[2];
  assign seg3 = seg_w[3];
  assign seg4 = seg_w[4];
  assign seg5 = seg_w[5];

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench: elapsed-seconds model vs
// stopwatch_core, directed plus random phases.
module tb_stopwatch_core;

  localparam int HRW  = 3;
  localparam int DAY  = HRW * 3600;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       run;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;

  stopwatch_core #(
    .HR_WRAP(HRW),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick),
    .start(start), .pause(pause), .run(run),
    .sec(sec), .min(min), .hr(hr),
    .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg3(seg3), .seg4(seg4), .seg5(seg5)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r;
    int t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  bit   m_run = 0;
  int   m_t = 0;

  function automatic logic [6:0] segof(int d);
    logic [6:0] lut [10];
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return lut[d];
  endfunction

  task automatic compare(string nm, bit r, int t);
    int h, m, s;
    logic [41:0] es, as;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    es = {segof(h / 10), segof(h % 10),
          segof(m / 10), segof(m % 10),
          segof(s / 10), segof(s % 10)};
    as = {seg5, seg4, seg3, seg2, seg1, seg0};
    checks++;
    if (run === r && int'(hr) == h &&
        int'(min) == m && int'(sec) == s &&
        as === es) begin
      passed++;
    end else begin
      $display("FAIL %s: got run=%0b %0d:%0d:%0d seg=%h, want run=%0b %0d:%0d:%0d seg=%h",
               nm, run, hr, min, sec, as,
               r, h, m, s, es);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compare("scoreboard", e.r, e.t);
    end
  end

  task automatic step(bit tk, bit st, bit ps);
    exp_t e;
    @(negedge clk);
    clr_n = 1'b1;
    tick  = tk;
    start = st;
    pause = ps;
    if (tk && m_run) m_t = (m_t + 1) % DAY;
    if (ps)      m_run = 0;
    else if (st) m_run = 1;
    e.r = m_run;
    e.t = m_t;
    q.push_back(e);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic chk(string nm, bit r,
                     int h, int m, int s);
    @(posedge clk);
    #2;
    compare(nm, r, h * 3600 + m * 60 + s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    q.delete();
    m_run = 0;
    m_t   = 0;
    #1;
    compare("reset_now", 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    #2;
    compare("por", 1'b0, 0);
    #20;
    ticks(5);
    chk("idle_5ticks", 0, 0, 0, 0);

    step(0, 1, 0);
    ticks(61);
    chk("basic_61", 1, 0, 1, 1);

    do_reset();
    step(0, 1, 0);
    ticks(10);
    chk("count_10", 1, 0, 0, 10);
    step(0, 0, 1);
    ticks(5);
    chk("paused_hold", 0, 0, 0, 10);
    step(0, 1, 0);
    ticks(3);
    chk("resume_13", 1, 0, 0, 13);
    step(0, 1, 1);
    ticks(3);
    chk("both_pause", 0, 0, 0, 13);
    step(0, 1, 0);
    ticks(2);
    chk("both_resume", 1, 0, 0, 15);
    step(1, 0, 1);
    chk("pause_tick_counts", 0, 0, 0, 16);
    step(1, 1, 0);
    chk("start_tick_waits", 1, 0, 0, 16);

    do_reset();
    step(0, 1, 0);
    ticks(137);
    chk("at_2_17", 1, 0, 2, 17);
    do_reset();
    ticks(4);
    chk("idle_after_clr", 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(1, 0) == 1,
           $urandom_range(7, 0) == 0,
           $urandom_range(15, 0) == 0);
    end

    do_reset();
    step(0, 1, 0);
    guard = 0;
    while (m_t != 3599 && guard < 20000) begin
      step(1, 0, 0);
      guard++;
    end
    step(1, 0, 0);
    chk("hr_carry", 1, 1, 0, 0);
    guard = 0;
    while (m_t != DAY - 2 && guard < 20000) begin
      step(1, 0, 0);
      guard++;
    end
    chk("pre_wrap", 1, HRW - 1, 59, 58);
    ticks(2);
    chk("wrap_zero", 1, 0, 0, 0);

    step(0, 0, 0);
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
